// File: rtl/ps2_scan_sequencer_if.sv
// ps2_scan_sequencer_if
//   Bundles the receiver-side byte stream, the event FIFO handshake and the
//   status/LED outputs of ps2_scan_sequencer.
//   slave  : view taken by the sequencer (consumes rx_*, evt_ready, clr_ovf;
//            drives the event, status and LED signals)
//   master : view taken by whatever feeds bytes and consumes events
interface ps2_scan_sequencer_if #(
  parameter int FIFO_AW = 2
);
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic             rx_err;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_break;
  logic             evt_ext;
  logic [FIFO_AW:0] fifo_count;
  logic             overflow;
  logic             clr_ovf;
  logic             proto_err;
  logic             busy;
  logic [7:0]       led;

  modport slave (
    input  rx_valid, rx_byte, rx_err, evt_ready, clr_ovf,
    output evt_valid, evt_code, evt_break, evt_ext, fifo_count,
           overflow, proto_err, busy, led
  );

  modport master (
    output rx_valid, rx_byte, rx_err, evt_ready, clr_ovf,
    input  evt_valid, evt_code, evt_break, evt_ext, fifo_count,
           overflow, proto_err, busy, led
  );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
//   Turns raw PS/2 receiver bytes into key events. E0 (extended) and F0
//   (break) prefixes are tracked by a small FSM; status bytes and errored
//   frames are dropped; a prefix left pending too long is abandoned. Events
//   go into a show-ahead FIFO with a valid/ready handshake, and the last
//   accepted make code is shown on the LEDs.
// Ports
//   dspclk : clock, all logic on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : ps2_scan_sequencer_if.slave
//            rx_valid/rx_byte/rx_err  byte stream from the receiver
//            evt_valid/evt_ready      head-of-FIFO handshake
//            evt_code/evt_break/evt_ext  head event fields
//            fifo_count               buffered events (0..2**FIFO_AW)
//            overflow/clr_ovf         sticky drop flag and its clear
//            proto_err                one-cycle error/timeout pulse
//            busy                     prefix pending
//            led                      last make code accepted
module ps2_scan_sequencer #(
  parameter int TIMEOUT_CYC = 10000,
  parameter int FIFO_AW     = 2
) (
  input logic                  dspclk,
  input logic                  reset,
  ps2_scan_sequencer_if.slave  bus
);

  localparam int               DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam int               CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]    TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } evt_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     tmo_cnt_reg;
  logic              tmo_hit;
  logic              is_status;
  logic              push_req;
  evt_t              push_evt;
  logic              perr_next;
  logic              proto_err_reg;
  logic              overflow_reg;
  logic [7:0]        led_reg;

  evt_t              mem_reg [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]  count_reg;
  logic              full, empty, pop, push_ok, drop;
  evt_t              head;

  // Bytes the keyboard sends outside of scan codes (BAT result, ACK,
  // echo, resend, error, Pause lead-in).
  always_comb begin
    is_status = bus.rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
  end

  // A received byte always beats a timeout that matures in the same cycle.
  assign tmo_hit = (state_reg != S_IDLE) && !bus.rx_valid && (tmo_cnt_reg == TMO_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge dspclk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    push_req   = 1'b0;
    push_evt   = '0;
    perr_next  = 1'b0;
    if (bus.rx_valid) begin
      if (bus.rx_err) begin
        state_next = S_IDLE;
        perr_next  = 1'b1;
      end else if (is_status) begin
        state_next = S_IDLE;
      end else begin
        unique case (state_reg)
          S_IDLE: begin
            if (bus.rx_byte == 8'hE0) begin
              state_next = S_EXT;
            end else if (bus.rx_byte == 8'hF0) begin
              state_next = S_BRK;
            end else begin
              push_req = 1'b1;
              push_evt = '{code: bus.rx_byte, brk: 1'b0, ext: 1'b0};
            end
          end
          S_EXT: begin
            if (bus.rx_byte == 8'hF0) begin
              state_next = S_EXT_BRK;
            end else if (bus.rx_byte != 8'hE0) begin
              push_req   = 1'b1;
              push_evt   = '{code: bus.rx_byte, brk: 1'b0, ext: 1'b1};
              state_next = S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            state_next = S_IDLE;
            if (bus.rx_byte == 8'hE0 || bus.rx_byte == 8'hF0) begin
              perr_next = 1'b1;
            end else begin
              push_req = 1'b1;
              push_evt = '{code: bus.rx_byte, brk: 1'b1, ext: (state_reg == S_EXT_BRK)};
            end
          end
          default: state_next = S_IDLE;
        endcase
      end
    end else if (tmo_hit) begin
      state_next = S_IDLE;
      perr_next  = 1'b1;
    end
  end

  // ------------------------------------------------------- prefix timeout
  always_ff @(posedge dspclk) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if (bus.rx_valid || state_reg == S_IDLE || tmo_hit) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // --------------------------------------------------------------- FIFO
  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign pop     = !empty && bus.evt_ready;
  // When full, a simultaneous pop frees the slot being written.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Storage is not reset: stale entries are never visible because the
  // head outputs are gated by evt_valid.
  always_ff @(posedge dspclk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_evt;
    end
  end

  always_ff @(posedge dspclk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Show-ahead: the head entry is read combinationally so it is presented
  // the cycle after it was written or after the previous pop.
  assign head = empty ? evt_t'('0) : mem_reg[rd_ptr_reg];

  // ------------------------------------------------- status and LEDs
  always_ff @(posedge dspclk) begin
    if (reset) begin
      proto_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      led_reg       <= 8'h00;
    end else begin
      proto_err_reg <= perr_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_reg <= 1'b0;
      end
      if (push_ok && !push_evt.brk) begin
        led_reg <= push_evt.code;
      end
    end
  end

  assign bus.evt_valid  = !empty;
  assign bus.evt_code   = head.code;
  assign bus.evt_break  = head.brk;
  assign bus.evt_ext    = head.ext;
  assign bus.fifo_count = count_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.proto_err  = proto_err_reg;
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.led        = led_reg;

endmodule
